masked_xor_reduce_acc: RTL and testbench
========================================

Name: masked_xor_reduce_acc

Overview:
- Share-wise, multi-lane XOR reduction with a valid/ready handshake, optional input pipeline register, and a multi-beat accumulate mode.
- Compresses WIDTH-bit words per lane per share to one parity bit, either per beat or XOR-accumulated over a burst terminated by in_last.
- Used in masked datapaths (linear layers, parity/checksum compression) ahead of nonlinear gadgets.
- Strictly share-separated: no signal ever combines bits of two different shares.

Parameters:
- WIDTH, 5, bits reduced per lane per share (>=1).
- SHARES, 3, number of Boolean shares (d+1).
- LANES, 4, independent reductions per share.
- REG_IN, 0, 1 inserts a registered reduction stage before the FSM (+1 cycle latency).
- MAX_BEATS, 16, maximum burst length in accumulate mode (>=2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous abort; flushes all state.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_last  in  1  last beat of an accumulate burst.
- acc_en  in  1  0 = per-beat mode, 1 = accumulate mode (sampled on the first beat of a burst).
- x  in  SHARES*LANES*WIDTH  input; share s, lane l occupies bits [(s*LANES+l)*WIDTH +: WIDTH].
- q  out  SHARES*LANES  result; share s, lane l at bit s*LANES+l.
- out_valid  out  1  q valid.
- out_ready  in  1  consumer accepts q.
- beats  out  $clog2(MAX_BEATS+1)  beats folded into the current q.
- ovf_err  out  1  sticky; set when a burst is force-terminated.

Behaviour:
- Reduction: r[s][l] = XOR of the WIDTH bits of share s, lane l. Computed per share; registers are per share.
- Reset (rst_n=0, async): q=0, accumulator=0, out_valid=0, beats=0, ovf_err=0, FSM=IDLE, stage-1 valid=0. in_ready is 1 after reset.
- clr=1: takes priority over all events. Next cycle:
  - FSM=IDLE, accumulator=0, out_valid=0, stage-1 valid=0, beats=0.
  - q and ovf_err are cleared; ovf_err is cleared only by clr or reset.
- REG_IN=1:
  - Stage 1 registers r, in_last, acc_en and a valid bit.
  - in_ready = !s1_valid || fsm_accept. Stage 1 holds its contents while the FSM stalls.
  - The FSM consumes stage-1 contents in place of the live input.
- Latency:
  - Accepted final beat to out_valid: 1 cycle (REG_IN=0) or 2 cycles (REG_IN=1).
  - Throughput: 1 beat per cycle when out_ready=1.
- FSM states:
  - IDLE: fsm_accept=1.
    - acc_en=0, or acc_en=1 with in_last=1: q<=r, beats<=1, go to HOLD.
    - acc_en=1 with in_last=0: acc<=r, beats<=1, go to ACCUM.
  - ACCUM: fsm_accept=1; acc_en is ignored.
    - Beat with in_last=0 and beats<MAX_BEATS-1: acc<=acc^r, beats+1.
    - Beat with in_last=1: q<=acc^r, beats+1, acc<=0, go to HOLD.
    - Beat with in_last=0 and beats==MAX_BEATS-1: treated as last, ovf_err<=1, go to HOLD.
    - No beat: state holds.
  - HOLD: out_valid=1; q and beats are stable until handshake; fsm_accept=out_ready.
    - out_ready && new beat: processed exactly as in IDLE in the same cycle (back-to-back, no bubble).
    - out_ready without a beat: go to IDLE, out_valid<=0.
- in_ready (REG_IN=0) = fsm_accept. It depends combinationally on out_ready only in HOLD.
- q, acc and beats hold their values when not updated. No cross-share logic anywhere; synthesis keep attributes apply on per-share registers.

Decomposition:
- Shared package masked_pkg: fsm state encoding (IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2), a share/lane bit-index helper function, and a BEATS_W helper.
- One sub-module: share_lane_reduce (combinational, WIDTH-bit XOR for one share-lane). It is instantiated SHARES*LANES times so the per-share hierarchy stays explicit for leakage evaluation.

Test Plan (SHARES=3, LANES=1, WIDTH=5, MAX_BEATS=4):
- Per-beat mode, REG_IN=0: x shares {10110, 00001, 11111}, acc_en=0, out_ready=1 -> next cycle out_valid=1, q=3'b111, beats=1.
- Accumulate burst: 3 beats where share 0 reduces to 1, 1, 0 and shares 1 and 2 reduce to 0; last on beat 3 -> single out_valid, q[0]=0, q[2:1]=0, beats=3, no intermediate out_valid.
- Backpressure: out_ready=0 for 3 cycles in HOLD -> in_ready=0, q stable. Then out_ready=1 with in_valid=1 -> same-cycle accept, next result valid one cycle later.
- Overflow: 4 beats with in_last=0 in accumulate mode -> 4th beat forces HOLD, beats=4, ovf_err=1 and stays 1 until clr.
- Abort and reset: clr mid-ACCUM after 2 beats -> out_valid=0, IDLE, next burst starts from acc=0. rst_n low mid-HOLD -> all outputs 0 immediately (async).
- REG_IN=1: same stimulus as the first scenario -> out_valid 2 cycles after accept. A 5-beat stream with out_ready=1 -> 5 consecutive results with no bubbles.

Source files
------------

// File: rtl/masked_pkg.sv
// Shared types and helpers for the masked XOR reduction accumulator.
// State encoding, share/lane bit indexing and beat-counter sizing.
package masked_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } fsm_state_t;

    function automatic int lane_idx(input int s, input int l, input int lanes);
        return s * lanes + l;
    endfunction

    function automatic int beats_w(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

endpackage

// File: rtl/share_lane_reduce.sv
// Parity of one share-lane word.
// Kept as its own module so every share has a visible hierarchy node.
module share_lane_reduce #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] x,
    output logic             r
);

    assign r = ^x;

endmodule

// File: rtl/masked_xor_reduce_acc.sv
// Share-separated multi-lane XOR reduction with burst accumulation.
// Optional registered reduction stage ahead of the control FSM.
module masked_xor_reduce_acc
    import masked_pkg::*;
#(
    parameter int WIDTH     = 5,
    parameter int SHARES    = 3,
    parameter int LANES     = 4,
    parameter int REG_IN    = 0,
    parameter int MAX_BEATS = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clr,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_last,
    input  logic                            acc_en,
    input  logic [SHARES*LANES*WIDTH-1:0]   x,
    output logic [SHARES*LANES-1:0]         q,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [beats_w(MAX_BEATS)-1:0]   beats,
    output logic                            ovf_err
);

    localparam int NB = SHARES * LANES;
    localparam int BW = beats_w(MAX_BEATS);

    logic [NB-1:0] r;
    logic [NB-1:0] f_r;
    logic          f_valid;
    logic          f_last;
    logic          f_acc_en;
    logic          fsm_accept;

    fsm_state_t    state_q, state_d;
    logic [BW-1:0] beats_q, beats_d;
    logic          q_ld, acc_ld, ovf_set;

    for (genvar s = 0; s < SHARES; s++) begin : g_red_s
        for (genvar l = 0; l < LANES; l++) begin : g_red_l
            share_lane_reduce #(.WIDTH(WIDTH)) u_red (
                .x (x[lane_idx(s, l, LANES)*WIDTH +: WIDTH]),
                .r (r[lane_idx(s, l, LANES)])
            );
        end
    end

    if (REG_IN != 0) begin : g_s1
        logic          s1_valid;
        logic          s1_last;
        logic          s1_acc_en;
        logic [NB-1:0] s1_r;

        assign in_ready = !s1_valid || fsm_accept;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_valid  <= 1'b0;
                s1_last   <= 1'b0;
                s1_acc_en <= 1'b0;
            end else if (clr) begin
                s1_valid  <= 1'b0;
            end else if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_last   <= in_last;
                    s1_acc_en <= acc_en;
                end
            end
        end

        // Stage-1 data registers are split per share.
        for (genvar s = 0; s < SHARES; s++) begin : g_sh
            (* keep *) logic [LANES-1:0] r_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else if (!clr && in_ready && in_valid) begin
                    r_q <= r[s*LANES +: LANES];
                end
            end

            assign s1_r[s*LANES +: LANES] = r_q;
        end

        assign f_valid  = s1_valid;
        assign f_last   = s1_last;
        assign f_acc_en = s1_acc_en;
        assign f_r      = s1_r;
    end else begin : g_live
        assign in_ready = fsm_accept;
        assign f_valid  = in_valid;
        assign f_last   = in_last;
        assign f_acc_en = acc_en;
        assign f_r      = r;
    end

    always_comb begin
        state_d    = state_q;
        beats_d    = beats_q;
        fsm_accept = 1'b0;
        q_ld       = 1'b0;
        acc_ld     = 1'b0;
        ovf_set    = 1'b0;
        unique case (state_q)
            IDLE:    fsm_accept = 1'b1;
            ACCUM:   fsm_accept = 1'b1;
            HOLD:    fsm_accept = out_ready;
            default: state_d    = IDLE;
        endcase
        if (f_valid && fsm_accept) begin
            if (state_q == ACCUM) begin
                beats_d = beats_q + BW'(1);
                if (f_last || beats_q == BW'(MAX_BEATS - 1)) begin
                    q_ld    = 1'b1;
                    ovf_set = !f_last;
                    state_d = HOLD;
                end else begin
                    acc_ld = 1'b1;
                end
            end else begin
                beats_d = BW'(1);
                if (!f_acc_en || f_last) begin
                    q_ld    = 1'b1;
                    state_d = HOLD;
                end else begin
                    acc_ld  = 1'b1;
                    state_d = ACCUM;
                end
            end
        end else if (state_q == HOLD && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beats_q <= '0;
            ovf_err <= 1'b0;
        end else if (clr) begin
            state_q <= IDLE;
            beats_q <= '0;
            ovf_err <= 1'b0;
        end else begin
            state_q <= state_d;
            beats_q <= beats_d;
            if (ovf_set) begin
                ovf_err <= 1'b1;
            end
        end
    end

    // acc is zero outside ACCUM, so acc^r also covers the direct load.
    for (genvar s = 0; s < SHARES; s++) begin : g_acc
        (* keep *) logic [LANES-1:0] acc_q;
        (* keep *) logic [LANES-1:0] q_q;
        logic [LANES-1:0] fold;

        assign fold = acc_q ^ f_r[s*LANES +: LANES];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_q <= '0;
                q_q   <= '0;
            end else if (clr) begin
                acc_q <= '0;
                q_q   <= '0;
            end else if (q_ld) begin
                q_q   <= fold;
                acc_q <= '0;
            end else if (acc_ld) begin
                acc_q <= fold;
            end
        end

        assign q[s*LANES +: LANES] = q_q;
    end

    assign out_valid = (state_q == HOLD);
    assign beats     = beats_q;

endmodule

// File: tb/tb_masked_xor_reduce_acc.sv
// Randomized bench for masked_xor_reduce_acc, REG_IN=0 and REG_IN=1.
// Expected results come from a parity-per-beat burst model.
module tb_masked_xor_reduce_acc;

    localparam int WIDTH     = 5;
    localparam int SHARES    = 3;
    localparam int LANES     = 1;
    localparam int MAX_BEATS = 4;
    localparam int NB        = SHARES * LANES;
    localparam int XW        = NB * WIDTH;
    localparam int BW        = $clog2(MAX_BEATS + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          acc_en = 1'b0;
    logic          out_ready = 1'b0;
    logic [XW-1:0] x = '0;

    logic          rdy0, ov0, oe0;
    logic          rdy1, ov1, oe1;
    logic [NB-1:0] q0, q1;
    logic [BW-1:0] bt0, bt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    masked_xor_reduce_acc #(
        .WIDTH(WIDTH), .SHARES(SHARES), .LANES(LANES),
        .REG_IN(0), .MAX_BEATS(MAX_BEATS)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(rdy0), .in_last(in_last),
        .acc_en(acc_en), .x(x), .q(q0), .out_valid(ov0),
        .out_ready(out_ready), .beats(bt0), .ovf_err(oe0)
    );

    masked_xor_reduce_acc #(
        .WIDTH(WIDTH), .SHARES(SHARES), .LANES(LANES),
        .REG_IN(1), .MAX_BEATS(MAX_BEATS)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(rdy1), .in_last(in_last),
        .acc_en(acc_en), .x(x), .q(q1), .out_valid(ov1),
        .out_ready(out_ready), .beats(bt1), .ovf_err(oe1)
    );

    function automatic logic [NB-1:0] parity(input logic [XW-1:0] v);
        logic [NB-1:0]    p;
        logic [WIDTH-1:0] w;
        p = '0;
        for (int i = 0; i < NB; i++) begin
            w    = v[i*WIDTH +: WIDTH];
            p[i] = ^w;
        end
        return p;
    endfunction

    function automatic logic [XW-1:0] rand_x();
        return XW'($urandom);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit sel, input logic [XW-1:0] v,
                        input logic last, input logic acc);
        int n;
        n = 0;
        x = v;
        in_last = last;
        acc_en = acc;
        in_valid = 1'b1;
        #1;
        while (!(sel ? rdy1 : rdy0) && n < 16) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 16) begin
            errors++;
            $display("FAIL send_accept in_ready low for %0d cycles, want 1", n);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (q0 !== '0) begin errors++; $display("FAIL reset_q got %b want 0", q0); end
        checks++;
        if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", ov0); end
        checks++;
        if (bt0 !== '0) begin errors++; $display("FAIL reset_beats got %0d want 0", bt0); end
        checks++;
        if (oe0 !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", oe0); end
        checks++;
        if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b%b want 11", rdy0, rdy1);
        end
    endtask

    task automatic test_per_beat();
        logic [XW-1:0] v;
        out_ready = 1'b1;
        v = {5'b11111, 5'b00001, 5'b10110};
        send(0, v, 1'b0, 1'b0);
        checks++;
        if (ov0 !== 1'b1 || q0 !== 3'b111 || bt0 !== BW'(1)) begin
            errors++;
            $display("FAIL per_beat_fixed got v=%b q=%b b=%0d want v=1 q=111 b=1", ov0, q0, bt0);
        end
        tick();
        checks++;
        if (ov0 !== 1'b0) begin errors++; $display("FAIL per_beat_release got %b want 0", ov0); end
        for (int i = 0; i < 6; i++) begin
            v = rand_x();
            send(0, v, 1'($urandom_range(0, 1)), 1'b0);
            checks++;
            if (ov0 !== 1'b1 || q0 !== parity(v) || bt0 !== BW'(1)) begin
                errors++;
                $display("FAIL per_beat_rand got v=%b q=%b b=%0d want v=1 q=%b b=1",
                         ov0, q0, bt0, parity(v));
            end
        end
        tick();
    endtask

    task automatic test_accum();
        logic [XW-1:0] v;
        logic [NB-1:0] exp;
        int            len;
        out_ready = 1'b1;
        send(0, {5'b00011, 5'b00000, 5'b00001}, 1'b0, 1'b1);
        checks++;
        if (ov0 !== 1'b0) begin errors++; $display("FAIL accum_mid1 out_valid got %b want 0", ov0); end
        send(0, {5'b00000, 5'b11000, 5'b00111}, 1'b0, 1'b1);
        checks++;
        if (ov0 !== 1'b0) begin errors++; $display("FAIL accum_mid2 out_valid got %b want 0", ov0); end
        send(0, {5'b11110, 5'b00000, 5'b00011}, 1'b1, 1'b1);
        checks++;
        if (ov0 !== 1'b1 || q0 !== 3'b000 || bt0 !== BW'(3)) begin
            errors++;
            $display("FAIL accum_fixed got v=%b q=%b b=%0d want v=1 q=000 b=3", ov0, q0, bt0);
        end
        tick();
        for (int k = 0; k < 8; k++) begin
            len = $urandom_range(1, MAX_BEATS);
            exp = '0;
            for (int b = 0; b < len; b++) begin
                v = rand_x();
                exp ^= parity(v);
                if (b > 0 && $urandom_range(0, 1) == 1) tick();
                send(0, v, 1'(b == len - 1), 1'b1);
            end
            checks++;
            if (ov0 !== 1'b1 || q0 !== exp || bt0 !== BW'(len) || oe0 !== 1'b0) begin
                errors++;
                $display("FAIL accum_rand len=%0d got v=%b q=%b b=%0d e=%b want v=1 q=%b b=%0d e=0",
                         len, ov0, q0, bt0, oe0, exp, len);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [XW-1:0] vs [6];
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) vs[i] = rand_x();
        x = vs[0];
        acc_en = 1'b0;
        in_last = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (ov0 !== 1'b1 || q0 !== parity(vs[k]) || bt0 !== BW'(1)) begin
                errors++;
                $display("FAIL b2b_%0d got v=%b q=%b b=%0d want v=1 q=%b b=1",
                         k, ov0, q0, bt0, parity(vs[k]));
            end
            if (k < 5) x = vs[k+1];
            else in_valid = 1'b0;
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [XW-1:0] a, b;
        out_ready = 1'b1;
        tick();
        tick();
        a = rand_x();
        b = a ^ XW'(1);
        out_ready = 1'b0;
        send(0, a, 1'b0, 1'b0);
        x = b;
        in_valid = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rdy0 !== 1'b0 || ov0 !== 1'b1 || q0 !== parity(a)) begin
                errors++;
                $display("FAIL bp_stall_%0d got r=%b v=%b q=%b want r=0 v=1 q=%b",
                         i, rdy0, ov0, q0, parity(a));
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (rdy0 !== 1'b1) begin errors++; $display("FAIL bp_ready got %b want 1", rdy0); end
        tick();
        in_valid = 1'b0;
        checks++;
        if (ov0 !== 1'b1 || q0 !== parity(b)) begin
            errors++;
            $display("FAIL bp_next got v=%b q=%b want v=1 q=%b", ov0, q0, parity(b));
        end
        tick();
    endtask

    task automatic test_overflow();
        logic [XW-1:0] v;
        logic [NB-1:0] exp;
        out_ready = 1'b1;
        exp = '0;
        for (int b = 0; b < MAX_BEATS; b++) begin
            v = rand_x();
            exp ^= parity(v);
            send(0, v, 1'b0, 1'b1);
            if (b == MAX_BEATS - 2) begin
                checks++;
                if (ov0 !== 1'b0 || oe0 !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_early got v=%b e=%b want v=0 e=0", ov0, oe0);
                end
            end
        end
        checks++;
        if (ov0 !== 1'b1 || bt0 !== BW'(MAX_BEATS) || oe0 !== 1'b1 || q0 !== exp) begin
            errors++;
            $display("FAIL ovf_force got v=%b b=%0d e=%b q=%b want v=1 b=%0d e=1 q=%b",
                     ov0, bt0, oe0, q0, MAX_BEATS, exp);
        end
        tick();
        send(0, rand_x(), 1'b0, 1'b0);
        checks++;
        if (oe0 !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", oe0); end
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (oe0 !== 1'b0 || q0 !== '0 || bt0 !== '0 || ov0 !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr got e=%b q=%b b=%0d v=%b want all 0", oe0, q0, bt0, ov0);
        end
    endtask

    task automatic test_abort();
        logic [XW-1:0] v3, v4;
        out_ready = 1'b1;
        send(0, rand_x(), 1'b0, 1'b1);
        send(0, rand_x(), 1'b0, 1'b1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (ov0 !== 1'b0 || bt0 !== '0) begin
            errors++;
            $display("FAIL abort_clr got v=%b b=%0d want v=0 b=0", ov0, bt0);
        end
        v3 = rand_x();
        v4 = rand_x();
        send(0, v3, 1'b0, 1'b1);
        send(0, v4, 1'b1, 1'b1);
        checks++;
        if (ov0 !== 1'b1 || q0 !== (parity(v3) ^ parity(v4)) || bt0 !== BW'(2)) begin
            errors++;
            $display("FAIL abort_fresh got v=%b q=%b b=%0d want v=1 q=%b b=2",
                     ov0, q0, bt0, parity(v3) ^ parity(v4));
        end
        out_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ov0 !== 1'b0 || q0 !== '0 || bt0 !== '0 || oe0 !== 1'b0) begin
            errors++;
            $display("FAIL async_rst got v=%b q=%b b=%0d e=%b want all 0", ov0, q0, bt0, oe0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reg_in();
        logic [XW-1:0] vs [5];
        out_ready = 1'b1;
        x = {5'b11111, 5'b00001, 5'b10110};
        acc_en = 1'b0;
        in_last = 1'b0;
        in_valid = 1'b1;
        #1;
        checks++;
        if (rdy1 !== 1'b1) begin errors++; $display("FAIL regin_ready got %b want 1", rdy1); end
        tick();
        in_valid = 1'b0;
        checks++;
        if (ov1 !== 1'b0) begin errors++; $display("FAIL regin_lat1 got %b want 0", ov1); end
        tick();
        checks++;
        if (ov1 !== 1'b1 || q1 !== 3'b111 || bt1 !== BW'(1)) begin
            errors++;
            $display("FAIL regin_lat2 got v=%b q=%b b=%0d want v=1 q=111 b=1", ov1, q1, bt1);
        end
        tick();
        tick();
        for (int i = 0; i < 5; i++) vs[i] = rand_x();
        x = vs[0];
        in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (k == 0) begin
                if (ov1 !== 1'b0) begin
                    errors++;
                    $display("FAIL regin_stream_0 got v=%b want 0", ov1);
                end
            end else if (ov1 !== 1'b1 || q1 !== parity(vs[k-1])) begin
                errors++;
                $display("FAIL regin_stream_%0d got v=%b q=%b want v=1 q=%b",
                         k, ov1, q1, parity(vs[k-1]));
            end
            if (k < 4) x = vs[k+1];
            else in_valid = 1'b0;
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_per_beat();
        test_accum();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_abort();
        test_reg_in();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
